// File: rtl/immgen_stage_if.sv
// immgen_stage_if: upstream {instr, pc} and downstream decoded-immediate
// valid/ready bundle for immgen_stage.
interface immgen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_tgt_vld;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt,
        output out_target, out_tgt_vld, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt,
        input  out_target, out_tgt_vld, out_illegal
    );
endinterface

// File: rtl/immgen_stage.sv
// immgen_stage: registered RV32I/RV64I immediate generator with a
// 2-entry skid buffer and a saturating illegal-entry counter.
module immgen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    immgen_stage_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immgen_stage: XLEN must be 32 or 64");
    end

    localparam logic RV64 = (XLEN == 64);

    typedef enum logic [2:0] {
        F_I  = 3'd0,
        F_S  = 3'd1,
        F_SB = 3'd2,
        F_U  = 3'd3,
        F_UJ = 3'd4,
        F_SH = 3'd5,
        F_DF = 3'd6,
        F_R  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      fmt;
        logic            tv;
        logic            ill;
    } ent_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0] ins;
    logic [6:0]  opc;
    logic        sh;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [31:0] imm32;
    fmt_e        fmt;
    logic        tv;
    logic        sh_ill;
    ent_t        dec;

    assign ins   = bus.in_instr;
    assign opc   = ins[6:0];
    assign sh    = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    assign i_imm = {{20{ins[31]}}, ins[31:20]};
    assign s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign u_imm = {ins[31:12], 12'b0};
    assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        fmt    = F_DF;
        imm32  = '0;
        tv     = 1'b0;
        sh_ill = 1'b0;
        unique case (opc)
            7'b0110011: fmt = F_R;
            7'b0111011: fmt = RV64 ? F_R : F_DF;
            7'b0010011: begin
                if (sh) begin
                    fmt    = F_SH;
                    imm32  = RV64 ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
                    sh_ill = !RV64 && ins[25];
                end else begin
                    fmt   = F_I;
                    imm32 = i_imm;
                end
            end
            7'b0011011: begin
                if (RV64) begin
                    fmt   = sh ? F_SH : F_I;
                    imm32 = sh ? {27'b0, ins[24:20]} : i_imm;
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                fmt   = F_I;
                imm32 = i_imm;
            end
            7'b1100011: begin
                fmt   = F_SB;
                imm32 = b_imm;
                tv    = 1'b1;
            end
            7'b0100011: begin
                fmt   = F_S;
                imm32 = s_imm;
            end
            7'b1101111: begin
                fmt   = F_UJ;
                imm32 = j_imm;
                tv    = 1'b1;
            end
            7'b0110111: begin
                fmt   = F_U;
                imm32 = u_imm;
            end
            7'b0010111: begin
                fmt   = F_U;
                imm32 = u_imm;
                tv    = 1'b1;
            end
            default: ;
        endcase
        dec.imm = sext(imm32);
        dec.fmt = fmt;
        dec.tv  = tv;
        dec.ill = sh_ill || (fmt == F_DF);
        dec.tgt = tv ? bus.in_pc + dec.imm : '0;
    end

    // main feeds the outputs; skid only fills while main is stalled
    ent_t             main_q, main_d, skid_q, skid_d;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_hs, out_hs;

    assign in_hs  = bus.in_valid && !skid_v_q;
    assign out_hs = main_v_q && bus.out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (out_hs && main_q.ill && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_hs || !main_v_q) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_hs;
                if (in_hs) main_d = dec;
            end
        end else if (in_hs) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready    = !skid_v_q;
    assign bus.out_valid   = main_v_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_target  = main_q.tgt;
    assign bus.out_tgt_vld = main_q.tv;
    assign bus.out_illegal = main_q.ill;
    assign illegal_cnt     = cnt_q;
endmodule

// File: tb/tb_immgen_stage.sv
// tb_immgen_stage: vector table plus scoreboard over XLEN=32, XLEN=64
// and a CNT_W=2 instance sharing one stimulus stream.
module tb_immgen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    always #5 clk = ~clk;

    immgen_stage_if #(.XLEN(32)) b32 ();
    immgen_stage_if #(.XLEN(64)) b64 ();
    immgen_stage_if #(.XLEN(32)) bc ();

    assign b32.in_valid  = in_valid;
    assign b32.in_instr  = in_instr;
    assign b32.in_pc     = in_pc;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_instr  = in_instr;
    assign b64.in_pc     = {32'h0, in_pc};
    assign b64.out_ready = out_ready;
    assign bc.in_valid   = in_valid;
    assign bc.in_instr   = in_instr;
    assign bc.in_pc      = in_pc;
    assign bc.out_ready  = out_ready;

    logic [15:0] cnt32, cnt64;
    logic [1:0]  cntc;

    immgen_stage #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .illegal_cnt(cnt32));
    immgen_stage #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64), .illegal_cnt(cnt64));
    immgen_stage #(.XLEN(32), .CNT_W(2)) uc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bc), .illegal_cnt(cntc));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  f32;
        logic [31:0] i32;
        logic [31:0] t32;
        logic        tv;
        logic        il32;
        logic [2:0]  f64;
        logic [63:0] i64;
        logic [63:0] t64;
        logic        il64;
    } vec_t;

    localparam int NV = 15;
    vec_t tab [NV];

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [31:0] pc,
        input logic [2:0] f32, input logic [31:0] i32, input logic [31:0] t32,
        input logic tv, input logic il32,
        input logic [2:0] f64, input logic [63:0] i64, input logic [63:0] t64,
        input logic il64);
        vec_t v;
        v.instr = instr; v.pc = pc;
        v.f32 = f32; v.i32 = i32; v.t32 = t32; v.tv = tv; v.il32 = il32;
        v.f64 = f64; v.i64 = i64; v.t64 = t64; v.il64 = il64;
        return v;
    endfunction

    int checks = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    int          q [$];
    int          cur = 0;
    int          pidx;
    logic        acc = 1'b0;
    logic        acc_prev = 1'b0;
    logic        strm = 1'b0;
    logic [15:0] m32 = '0;
    logic [15:0] m64 = '0;
    logic [1:0]  mc = '0;

    always @(negedge clk) begin
        acc_prev = acc;
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            m32 = '0;
            m64 = '0;
            mc  = '0;
        end else begin
            chk("cnt32", 64'(cnt32), 64'(m32));
            chk("cnt64", 64'(cnt64), 64'(m64));
            chk("cnt_sat", 64'(cntc), 64'(mc));
            if (strm) begin
                chk("stream_in_ready", 64'(b32.in_ready), 64'(1));
                if (acc_prev) chk("latency1", 64'(b32.out_valid), 64'(1));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (b32.out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL sb_underflow act=output exp=none");
                    end else begin
                        pidx = q.pop_front();
                        chk($sformatf("fmt32[%0d]", pidx), 64'(b32.out_fmt), 64'(tab[pidx].f32));
                        chk($sformatf("imm32[%0d]", pidx), 64'(b32.out_imm), 64'(tab[pidx].i32));
                        chk($sformatf("tgt32[%0d]", pidx), 64'(b32.out_target), 64'(tab[pidx].t32));
                        chk($sformatf("tv32[%0d]", pidx), 64'(b32.out_tgt_vld), 64'(tab[pidx].tv));
                        chk($sformatf("ill32[%0d]", pidx), 64'(b32.out_illegal), 64'(tab[pidx].il32));
                        chk($sformatf("v64[%0d]", pidx), 64'(b64.out_valid), 64'(1));
                        chk($sformatf("fmt64[%0d]", pidx), 64'(b64.out_fmt), 64'(tab[pidx].f64));
                        chk($sformatf("imm64[%0d]", pidx), b64.out_imm, tab[pidx].i64);
                        chk($sformatf("tgt64[%0d]", pidx), b64.out_target, tab[pidx].t64);
                        chk($sformatf("tv64[%0d]", pidx), 64'(b64.out_tgt_vld), 64'(tab[pidx].tv));
                        chk($sformatf("ill64[%0d]", pidx), 64'(b64.out_illegal), 64'(tab[pidx].il64));
                        if (tab[pidx].il32) begin
                            m32 = m32 + 16'd1;
                            if (mc != 2'd3) mc = mc + 2'd1;
                        end
                        if (tab[pidx].il64) m64 = m64 + 16'd1;
                    end
                end
                if (in_valid && b32.in_ready) begin
                    q.push_back(cur);
                    acc = 1'b1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int idx);
        cur      = idx;
        in_instr = tab[idx].instr;
        in_pc    = tab[idx].pc;
        in_valid = 1'b1;
    endtask

    task automatic send(input int idx);
        int n;
        present(idx);
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        chk($sformatf("accept[%0d]", idx), 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        tick();
        chk("drain_idle", 64'(b32.out_valid), 64'(0));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 64'(b32.out_valid), 64'(0));
        chk({nm, "_ready"}, 64'(b32.in_ready), 64'(1));
        chk({nm, "_imm"}, 64'(b32.out_imm), 64'(0));
        chk({nm, "_fmt"}, 64'(b32.out_fmt), 64'(0));
        chk({nm, "_tgt"}, 64'(b32.out_target), 64'(0));
        chk({nm, "_tv"}, 64'(b32.out_tgt_vld), 64'(0));
        chk({nm, "_ill"}, 64'(b32.out_illegal), 64'(0));
        chk({nm, "_cnt"}, 64'(cnt32), 64'(0));
        chk({nm, "_cntc"}, 64'(cntc), 64'(0));
        chk({nm, "_v64"}, 64'(b64.out_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = mk(32'hFE000EE3, 32'h100, 3'd2, 32'hFFFFFFFC, 32'h000000FC, 1, 0,
                     3'd2, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 0);
        tab[1]  = mk(32'h03F09093, 32'h100, 3'd5, 32'h1F, 32'h0, 0, 1,
                     3'd5, 64'h3F, 64'h0, 0);
        tab[2]  = mk(32'hFFF00093, 32'h100, 3'd0, 32'hFFFFFFFF, 32'h0, 0, 0,
                     3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0);
        tab[3]  = mk(32'h800000B7, 32'h100, 3'd3, 32'h80000000, 32'h0, 0, 0,
                     3'd3, 64'hFFFFFFFF80000000, 64'h0, 0);
        tab[4]  = mk(32'h12345097, 32'h1000, 3'd3, 32'h12345000, 32'h12346000, 1, 0,
                     3'd3, 64'h12345000, 64'h12346000, 0);
        tab[5]  = mk(32'h008000EF, 32'h100, 3'd4, 32'h8, 32'h108, 1, 0,
                     3'd4, 64'h8, 64'h108, 0);
        tab[6]  = mk(32'hFFDFF06F, 32'h0, 3'd4, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0,
                     3'd4, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
        tab[7]  = mk(32'hFE20AC23, 32'h100, 3'd1, 32'hFFFFFFF8, 32'h0, 0, 0,
                     3'd1, 64'hFFFFFFFFFFFFFFF8, 64'h0, 0);
        tab[8]  = mk(32'h003100B3, 32'h100, 3'd7, 32'h0, 32'h0, 0, 0,
                     3'd7, 64'h0, 64'h0, 0);
        tab[9]  = mk(32'h003100BB, 32'h100, 3'd6, 32'h0, 32'h0, 0, 1,
                     3'd7, 64'h0, 64'h0, 0);
        tab[10] = mk(32'h004100E7, 32'h100, 3'd0, 32'h4, 32'h0, 0, 0,
                     3'd0, 64'h4, 64'h0, 0);
        tab[11] = mk(32'h0000007F, 32'h100, 3'd6, 32'h0, 32'h0, 0, 1,
                     3'd6, 64'h0, 64'h0, 1);
        tab[12] = mk(32'h01F0909B, 32'h100, 3'd6, 32'h0, 32'h0, 0, 1,
                     3'd5, 64'h1F, 64'h0, 0);
        tab[13] = mk(32'h4050D093, 32'h100, 3'd5, 32'h5, 32'h0, 0, 0,
                     3'd5, 64'h5, 64'h0, 0);
        tab[14] = mk(32'h7FF12083, 32'h100, 3'd0, 32'h7FF, 32'h0, 0, 0,
                     3'd0, 64'h7FF, 64'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        tick();

        // whole table streamed with the sink always ready
        out_ready = 1'b1;
        strm      = 1'b1;
        for (int i = 0; i < NV; i++) send(i);
        drain();
        strm = 1'b0;

        // backpressure: two accepted, third waits on in_ready
        out_ready = 1'b0;
        send(2);
        send(3);
        chk("bp_ready_low", 64'(b32.in_ready), 64'(0));
        present(4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_ready", 64'(b32.in_ready), 64'(0));
            chk("bp_hold_valid", 64'(b32.out_valid), 64'(1));
            chk("bp_hold_imm", 64'(b32.out_imm), 64'(tab[2].i32));
            chk("bp_hold_fmt", 64'(b32.out_fmt), 64'(tab[2].f32));
        end
        out_ready = 1'b1;
        send(4);
        drain();

        // flush with both entries held, then with a live input dropped
        out_ready = 1'b0;
        send(5);
        send(7);
        present(8);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", 64'(b32.out_valid), 64'(0));
        chk("flush_full_ready", 64'(b32.in_ready), 64'(1));
        send(10);
        present(11);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_drop_valid", 64'(b32.out_valid), 64'(0));
        chk("flush_drop_ready", 64'(b32.in_ready), 64'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("flush_lost", 64'(b32.out_valid), 64'(0));
        end

        // saturating counter: five illegal entries
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt_reset", 64'(cntc), 64'(0));
        for (int k = 0; k < 5; k++) send(11);
        drain();
        chk("cnt_sat_final", 64'(cntc), 64'(3));
        chk("cnt32_final", 64'(cnt32), 64'(5));
        chk("cnt64_final", 64'(cnt64), 64'(5));

        // asynchronous reset while streaming
        present(2);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        send(13);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
